// File: rtl/mips_gpio_port.sv
// Memory-mapped GPIO port: 32-bit output latch, 8 synchronised/debounced inputs
// with masked rising-edge capture, write-1-to-clear flags and a level interrupt.
module mips_gpio_port #(
  parameter logic [31:0] BASE_ADDR       = 32'h1001_1000,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        Select,
  output logic [31:0] PortOut,
  output logic        Irq
);

  typedef enum logic [1:0] {
    OFF_PORT_OUT   = 2'd0,
    OFF_PORT_IN    = 2'd1,
    OFF_EDGE_FLAGS = 2'd2,
    OFF_EDGE_MASK  = 2'd3
  } regOffset_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  regOffset_t       offset;
  logic             wrEn;
  logic             unusedAddrBits;

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       deb;
  logic [7:0]       debNext;
  logic [CNT_W-1:0] cnt     [8];
  logic [CNT_W-1:0] cntNext [8];

  logic [7:0]       edgeFlags;
  logic [7:0]       edgeMask;
  logic [7:0]       riseSet;
  logic [7:0]       clrBits;
  logic [7:0]       flagsNext;

  assign Select         = (Address[31:4] == BASE_ADDR[31:4]);
  assign offset         = regOffset_t'(Address[3:2]);
  assign wrEn           = MemWrite & Select;
  assign unusedAddrBits = ^Address[1:0];

  always_comb begin
    debNext = deb;
    cntNext = cnt;
    for (int unsigned i = 0; i < 8; i++) begin
      if (sync2[i] == deb[i]) begin
        cntNext[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        debNext[i] = sync2[i];
        cntNext[i] = '0;
      end else begin
        cntNext[i] = cnt[i] + CNT_ONE;
      end
    end
  end

  // Capture uses the pre-write mask, and a same-edge rise overrides the W1C clear.
  always_comb begin
    riseSet   = debNext & ~deb & edgeMask;
    clrBits   = (wrEn && offset == OFF_EDGE_FLAGS) ? WriteData[7:0] : '0;
    flagsNext = (edgeFlags & ~clrBits) | riseSet;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      deb       <= '0;
      for (int unsigned i = 0; i < 8; i++) cnt[i] <= '0;
      edgeFlags <= '0;
      edgeMask  <= '0;
      PortOut   <= '0;
    end else begin
      sync1     <= PortIn;
      sync2     <= sync1;
      deb       <= debNext;
      for (int unsigned i = 0; i < 8; i++) cnt[i] <= cntNext[i];
      edgeFlags <= flagsNext;
      if (wrEn && offset == OFF_PORT_OUT)  PortOut  <= WriteData;
      if (wrEn && offset == OFF_EDGE_MASK) edgeMask <= WriteData[7:0];
    end
  end

  assign Irq = |(edgeFlags & edgeMask);

  always_comb begin
    ReadData = '0;
    if (MemRead && Select) begin
      unique case (offset)
        OFF_PORT_OUT:   ReadData = PortOut;
        OFF_PORT_IN:    ReadData = {24'b0, deb};
        OFF_EDGE_FLAGS: ReadData = {24'b0, edgeFlags};
        OFF_EDGE_MASK:  ReadData = {24'b0, edgeMask};
        default:        ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_gpio_port.sv
// Directed + randomized bench for mips_gpio_port against a sliding-window reference model.
module tb_mips_gpio_port;

  localparam logic [31:0] BASE = 32'h1001_1000;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [7:0]  PortIn;
  logic [31:0] ReadData;
  logic        Select;
  logic [31:0] PortOut;
  logic        Irq;

  always #5 clk = ~clk;

  mips_gpio_port #(
    .BASE_ADDR(BASE),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Address(Address),
    .WriteData(WriteData),
    .MemWrite(MemWrite),
    .MemRead(MemRead),
    .PortIn(PortIn),
    .ReadData(ReadData),
    .Select(Select),
    .PortOut(PortOut),
    .Irq(Irq)
  );

  int passes = 0;
  int total  = 0;

  logic [31:0] mOut;
  logic [7:0]  mDeb, mFlags, mMask;
  logic [7:0]  hist [DEB+1];   // hist[0] = pin sampled at last edge, hist[1] = at the edge before
  logic [7:0]  pinNow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'h0;
    case (a[3:2])
      2'd0:    return mOut;
      2'd1:    return {24'b0, mDeb};
      2'd2:    return {24'b0, mFlags};
      default: return {24'b0, mMask};
    endcase
  endfunction

  task automatic modelReset();
    mOut = '0; mDeb = '0; mFlags = '0; mMask = '0;
    for (int k = 0; k <= DEB; k++) hist[k] = '0;
  endtask

  // A debounced bit flips once the pin value seen by the second sync stage has
  // disagreed with it over the last DEB consecutive edges.
  task automatic modelEdge();
    logic [7:0] nd, rise, clr;
    logic       sel;
    nd = mDeb;
    for (int i = 0; i < 8; i++) begin
      bit allDiff = 1'b1;
      for (int j = 1; j <= DEB; j++) if (hist[j][i] == mDeb[i]) allDiff = 1'b0;
      if (allDiff) nd[i] = ~mDeb[i];
    end
    rise = nd & ~mDeb & mMask;
    clr  = '0;
    sel  = (Address[31:4] == BASE[31:4]);
    if (MemWrite && sel) begin
      case (Address[3:2])
        2'd0: mOut  = WriteData;
        2'd2: clr   = WriteData[7:0];
        2'd3: mMask = WriteData[7:0];
        default: ;
      endcase
    end
    mFlags = (mFlags & ~clr) | rise;
    mDeb   = nd;
    for (int k = DEB; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = PortIn;
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic mw, input logic mr);
    Address = a; WriteData = wd; MemWrite = mw; MemRead = mr; PortIn = pinNow;
    #1;
    chk("select", {31'b0, Select}, {31'b0, (a[31:4] == BASE[31:4])});
    chk("readData", ReadData, mr ? modelRead(a) : 32'h0);
    @(posedge clk);
    modelEdge();
    #2;
    chk("portOut", PortOut, mOut);
    chk("irq", {31'b0, Irq}, {31'b0, |(mFlags & mMask)});
    MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    step(a, d, 1'b1, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Address = a; MemRead = 1'b1;
    #1;
    chk(tag, ReadData, exp);
    MemRead = 1'b0;
  endtask

  initial begin
    reset = 1'b0; Address = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0;
    pinNow = 8'h00; PortIn = 8'h00;
    modelReset();

    // reset and release
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    chk("rst_portOut", PortOut, 32'h0);
    chk("rst_irq", {31'b0, Irq}, 32'h0);
    rd("rst_portIn", BASE + 32'h4, 32'h0);
    rd("rst_flags", BASE + 32'h8, 32'h0);
    rd("rst_mask", BASE + 32'hC, 32'h0);

    // PORT_OUT and decode
    sw(BASE, 32'hDEAD_BEEF);
    chk("portOut_dead", PortOut, 32'hDEAD_BEEF);
    rd("portOut_rb", BASE, 32'hDEAD_BEEF);
    sw(BASE + 32'h4, 32'hFFFF_FFFF);
    rd("portIn_ro", BASE + 32'h4, 32'h0);
    sw(32'h1001_0FFC, 32'h1234_5678);
    chk("outside_nowrite", PortOut, 32'hDEAD_BEEF);
    Address = 32'h1001_0FFC; MemRead = 1'b1; #1;
    chk("outside_select", {31'b0, Select}, 32'h0);
    chk("outside_read", ReadData, 32'h0);
    MemRead = 1'b0;
    rd("byteaddr_ignored", BASE + 32'h3, 32'hDEAD_BEEF);

    // debounce latency: sampled at edge k, visible after edge k+5
    pinNow = 8'h01;
    idle(1);
    idle(4);
    rd("deb_early", BASE + 32'h4, 32'h0);
    idle(1);
    rd("deb_exact", BASE + 32'h4, 32'h1);

    // 3-cycle glitch on bit1 never propagates
    pinNow = 8'h03; idle(3);
    pinNow = 8'h01; idle(8);
    rd("glitch", BASE + 32'h4, 32'h1);
    pinNow = 8'h00; idle(7);

    // edge capture with mask 05
    sw(BASE + 32'hC, 32'h5);
    pinNow = 8'h07; idle(7);
    rd("flags_set", BASE + 32'h8, 32'h5);
    chk("irq_set", {31'b0, Irq}, 32'h1);
    pinNow = 8'h00; idle(7);
    rd("flags_fall", BASE + 32'h8, 32'h5);

    // W1C and set-over-clear priority
    sw(BASE + 32'h8, 32'h1);
    rd("w1c_bit0", BASE + 32'h8, 32'h4);
    sw(BASE + 32'h8, 32'h4);
    rd("w1c_bit2", BASE + 32'h8, 32'h0);
    pinNow = 8'h04;
    idle(5);
    sw(BASE + 32'h8, 32'h4);
    rd("set_wins", BASE + 32'h8, 32'h4);
    sw(BASE + 32'hC, 32'h0);
    chk("mask_off_irq", {31'b0, Irq}, 32'h0);
    rd("mask_off_flags", BASE + 32'h8, 32'h4);

    // async reset mid-debounce with flags = 05
    sw(BASE + 32'hC, 32'h5);
    pinNow = 8'h05; idle(7);
    rd("pre_rst_flags", BASE + 32'h8, 32'h5);
    pinNow = 8'h00; idle(2);
    reset = 1'b0;
    #1;
    chk("arst_portOut", PortOut, 32'h0);
    chk("arst_irq", {31'b0, Irq}, 32'h0);
    rd("arst_portIn", BASE + 32'h4, 32'h0);
    rd("arst_flags", BASE + 32'h8, 32'h0);
    rd("arst_mask", BASE + 32'hC, 32'h0);
    reset = 1'b1;
    modelReset();
    idle(8);
    rd("post_rst_deb", BASE + 32'h4, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, wd;
      logic        mw, mr;
      int unsigned op;
      if ($urandom_range(0, 5) == 0) pinNow = 8'($urandom);
      op = $urandom_range(0, 9);
      wd = $urandom;
      mw = 1'b1;
      a  = BASE + {28'h0, 2'($urandom_range(0, 3)), 2'($urandom)};
      case (op)
        0: a[3:2] = 2'd0;
        1: a[3:2] = 2'd1;
        2: a[3:2] = 2'd2;
        3: a[3:2] = 2'd3;
        4: a = ($urandom_range(0, 1) != 0) ? BASE - 32'h4 : BASE + 32'h10 + {$urandom_range(0, 15), 2'b00};
        default: mw = 1'b0;
      endcase
      if (op == 2 && $urandom_range(0, 2) != 0) mw = 1'b0;
      mr = ($urandom_range(0, 1) != 0);
      step(a, wd, mw, mr);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
